// File: rtl/sharpen_seq_ctrl_if.sv
// Memory port plus window/datapath control bundle between the sharpening
// sequencer (master) and the memory/datapath side (slave).
interface sharpen_seq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              win_load;
  logic [3:0]        win_idx;
  logic              calc_go;
  logic              calc_bypass;
  logic              calc_done;

  modport master (
    output mem_req, mem_we, mem_addr, win_load, win_idx, calc_go, calc_bypass,
    input  mem_ack, calc_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, win_load, win_idx, calc_go, calc_bypass,
    output mem_ack, calc_done
  );
endinterface

// File: rtl/sharpen_seq_ctrl.sv
// Raster-scan sequencer for the sharpening engine: fetches each pixel's 3x3
// window (centre only on the border), runs the datapath, writes the result.
module sharpen_seq_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  sharpen_seq_ctrl_if.master bus,
  output logic               busy,
  output logic               done
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_GAP, S_CALC, S_CALC_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            state, state_d;
  logic              start_q;
  logic              trig;
  logic              border;
  logic              last_read;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        k;
  logic [3:0]        slot;
  logic [1:0]        ky, kx;
  logic [ADDR_W-1:0] row_a, col_a, src_addr, dst_addr;

  assign trig      = start & ~start_q;
  assign border    = (x == '0) | (y == '0) | (x == X_LAST) | (y == Y_LAST);
  assign last_read = border | (k == 4'd8);
  // k counts reads done; border pixels fetch only the centre slot.
  assign slot      = border ? 4'd4 : k;

  always_comb begin
    case (slot)
      4'd0:    {ky, kx} = 4'b00_00;
      4'd1:    {ky, kx} = 4'b00_01;
      4'd2:    {ky, kx} = 4'b00_10;
      4'd3:    {ky, kx} = 4'b01_00;
      4'd4:    {ky, kx} = 4'b01_01;
      4'd5:    {ky, kx} = 4'b01_10;
      4'd6:    {ky, kx} = 4'b10_00;
      4'd7:    {ky, kx} = 4'b10_01;
      4'd8:    {ky, kx} = 4'b10_10;
      default: {ky, kx} = 4'b01_01;
    endcase
  end

  always_comb begin
    row_a    = ADDR_W'(y) + ADDR_W'(ky) - ONE_A;
    col_a    = ADDR_W'(x) + ADDR_W'(kx) - ONE_A;
    src_addr = SRC_A + row_a * W_A + col_a;
    dst_addr = DST_A + ADDR_W'(y) * W_A + ADDR_W'(x);
  end

  always_comb begin
    state_d         = state;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.win_load    = 1'b0;
    bus.calc_go     = 1'b0;
    bus.calc_bypass = 1'b0;
    done            = 1'b0;
    unique case (state)
      S_IDLE: if (trig) state_d = S_READ;
      S_READ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = src_addr;
        if (bus.mem_ack) begin
          bus.win_load = 1'b1;
          state_d      = S_GAP;
        end
      end
      S_GAP: state_d = last_read ? S_CALC : S_READ;
      S_CALC: begin
        bus.calc_go     = 1'b1;
        bus.calc_bypass = border;
        state_d         = S_CALC_WAIT;
      end
      S_CALC_WAIT: if (bus.calc_done) state_d = S_WRITE;
      S_WRITE: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = dst_addr;
        if (bus.mem_ack) state_d = S_NEXT;
      end
      S_NEXT: state_d = ((x != X_LAST) || (y != Y_LAST)) ? S_READ : S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.win_idx = (state == S_READ) ? slot : k;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      start_q <= 1'b1;
      x       <= '0;
      y       <= '0;
      k       <= '0;
    end else begin
      start_q <= start;
      state   <= state_d;
      case (state)
        S_IDLE: if (trig) begin
          x <= '0;
          y <= '0;
          k <= '0;
        end
        S_GAP: if (!last_read) k <= k + 4'd1;
        S_NEXT: begin
          k <= '0;
          if (x != X_LAST) begin
            x <= x + XW'(1);
          end else begin
            x <= '0;
            if (y != Y_LAST) y <= y + YW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sharpen_seq_ctrl.sv
// Bench for sharpen_seq_ctrl: memory/datapath responder with optional random
// latencies, expected transaction queues and a reference sharpened image.
module tb_sharpen_seq_ctrl;
  localparam int AW  = 10;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int SRC = 0;
  localparam int DST = 256;
  localparam int AMASK = (1 << AW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic busy, done;

  sharpen_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  sharpen_seq_ctrl #(
    .ADDR_W(AW), .IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int idx; } rd_t;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  mem [1024];
  int  win [9];
  int  result = 0;
  rd_t exp_rd [$];
  int  exp_wr [$];
  int  exp_byp [$];
  int  n_rd = 0, n_wr = 0, n_byp = 0, n_done = 0, n_busy = 0;
  int  cyc = 0, last_ack_cyc = 0;
  bit  rand_mode = 1'b0;
  int  adly = 1, wcnt = 0, cdly = 0, ccnt = 0;
  bit  cpend = 1'b0;
  logic prev_req = 1'b0, prev_we = 1'b0, prev_xfer = 1'b0, prev_go = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic xfer;
  rd_t  e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic bit is_border(input int xx, input int yy);
    return (xx == 0) || (yy == 0) || (xx == W - 1) || (yy == H - 1);
  endfunction

  function automatic int src_px(input int xx, input int yy);
    return mem[(SRC + yy * W + xx) & AMASK];
  endfunction

  // Fresh random source image, cleared destination, expected transaction lists.
  task automatic new_run();
    for (int i = 0; i < W * H; i++) begin
      mem[(SRC + i) & AMASK] = int'($urandom_range(0, 255));
      mem[(DST + i) & AMASK] = -1;
    end
    exp_rd.delete(); exp_wr.delete(); exp_byp.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (is_border(xx, yy)) exp_rd.push_back('{(SRC + yy * W + xx) & AMASK, 4});
        else
          for (int kk = 0; kk < 9; kk++)
            exp_rd.push_back('{(SRC + (yy + kk / 3 - 1) * W + xx + kk % 3 - 1) & AMASK, kk});
        exp_wr.push_back((DST + yy * W + xx) & AMASK);
        exp_byp.push_back(int'(is_border(xx, yy)));
      end
    n_rd = 0; n_wr = 0; n_byp = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    int ref_v;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (is_border(xx, yy)) ref_v = src_px(xx, yy);
        else ref_v = 5 * src_px(xx, yy) - src_px(xx, yy - 1) - src_px(xx - 1, yy)
                     - src_px(xx + 1, yy) - src_px(xx, yy + 1);
        if (mem[(DST + yy * W + xx) & AMASK] != ref_v) bad++;
      end
    check(tag, bad, 0);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    start = 1'b0;
    check("done_in_time", n_done, 1);
  endtask

  // Memory and datapath responder plus protocol monitor, one pass per cycle.
  always @(negedge clk) begin
    if (reset) begin
      bus.mem_ack = 1'b0; bus.calc_done = 1'b0;
      wcnt = 0; adly = 1; cpend = 1'b0; ccnt = 0;
      prev_req = 1'b0; prev_we = 1'b0; prev_xfer = 1'b0; prev_go = 1'b0; prev_addr = '0;
    end else begin
      if (cpend) begin
        if (ccnt >= cdly) begin bus.calc_done = 1'b1; cpend = 1'b0; end
        else begin bus.calc_done = 1'b0; ccnt++; end
      end
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (wcnt >= adly) bus.mem_ack = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
        if (rand_mode && $urandom_range(0, 3) == 0) bus.mem_ack = 1'b1;
      end
      #1;
      cyc++;
      xfer = bus.mem_req & bus.mem_ack;
      if (prev_xfer) check("gap_after_ack", bus.mem_req, 0);
      else if (prev_req && bus.mem_req) begin
        check("addr_stable", bus.mem_addr, prev_addr);
        check("we_stable", bus.mem_we, prev_we);
      end
      check("win_load", bus.win_load, xfer & ~bus.mem_we);
      if (prev_go) check("calc_go_pulse", bus.calc_go, 0);
      if (xfer && !bus.mem_we) begin
        n_rd++;
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          check("rd_addr", bus.mem_addr, e.addr);
          check("win_idx", bus.win_idx, e.idx);
        end
        if (bus.win_idx < 4'd9) win[bus.win_idx] = mem[bus.mem_addr];
        last_ack_cyc = cyc;
      end
      if (xfer && bus.mem_we) begin
        n_wr++;
        if (exp_wr.size() > 0) check("wr_addr", bus.mem_addr, exp_wr.pop_front());
        mem[bus.mem_addr] = result;
      end
      if (bus.calc_go) begin
        check("go_after_ack", cyc - last_ack_cyc, 2);
        if (exp_byp.size() > 0) check("bypass", bus.calc_bypass, exp_byp.pop_front());
        n_byp += int'(bus.calc_bypass);
        result = bus.calc_bypass ? win[4] : 5 * win[4] - win[1] - win[3] - win[5] - win[7];
        cpend = 1'b1; ccnt = 0;
        cdly = rand_mode ? int'($urandom_range(0, 5)) : 0;
      end
      if (xfer) begin
        wcnt = 0;
        adly = rand_mode ? int'($urandom_range(0, 5)) : 1;
      end
      n_done += int'(done);
      n_busy += int'(busy);
      prev_req = bus.mem_req; prev_we = bus.mem_we; prev_addr = bus.mem_addr;
      prev_xfer = xfer; prev_go = bus.calc_go;
    end
  end

  initial begin
    // Reset state, with start held high throughout.
    tick();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_win_load", bus.win_load, 0);
    check("rst_win_idx", bus.win_idx, 0);
    check("rst_calc_go", bus.calc_go, 0);
    check("rst_calc_bypass", bus.calc_bypass, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("held_start_no_run", busy, 0);
    check("held_start_no_reads", n_rd, 0);

    // Run 1: fixed one-cycle ack and calc latency.
    new_run();
    start = 1'b0;
    tick();
    start = 1'b1;
    check("busy_before_edge", busy, 0);
    tick();
    check("busy_after_edge", busy, 1);
    wait_done(2000, 1'b0);
    repeat (4) tick();
    check("r1_reads", n_rd, 48);
    check("r1_writes", n_wr, 16);
    check("r1_bypass", n_byp, 12);
    check("r1_done_pulses", n_done, 1);
    check("r1_busy_cycles", n_busy, 4 * 32 + 12 * 8 + 1);
    check("r1_busy_low", busy, 0);
    check_image("r1_image");

    // Run 2: random latencies, stray acks, start toggled during the run.
    rand_mode = 1'b1;
    new_run();
    start = 1'b1;
    tick();
    wait_done(6000, 1'b1);
    repeat (6) tick();
    check("r2_reads", n_rd, 48);
    check("r2_writes", n_wr, 16);
    check("r2_bypass", n_byp, 12);
    check("r2_done_pulses", n_done, 1);
    check("r2_busy_low", busy, 0);
    check_image("r2_image");
    rand_mode = 1'b0;

    // Run 3: reset during pixel (2,1) reads, then restart from (0,0).
    new_run();
    start = 1'b1;
    tick();
    for (int i = 0; i < 2000 && !(n_wr == 6 && bus.mem_req && !bus.mem_we); i++) tick();
    check("reach_px21", n_wr, 6);
    reset = 1'b1;
    tick();
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_no_done", n_done, 0);
    check("rst_mid_no_restart", busy, 0);
    new_run();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    wait_done(2000, 1'b0);
    repeat (4) tick();
    check("r3_reads", n_rd, 48);
    check("r3_writes", n_wr, 16);
    check("r3_done_pulses", n_done, 1);
    check_image("r3_image");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sharpen_seq_ctrl.md
Name: sharpen_seq_ctrl

Overview:
Sequencer for the image-sharpening engine attached to the DLX processor. A rising edge on the core's start level launches a raster scan of a source image held in data memory. For each pixel the block fetches the 3x3 neighbourhood, or the centre only for border pixels, into the window register file, triggers the sharpening datapath, and writes the result to the destination image. It owns the single memory port while busy and reports completion to the core.

Parameters:
ADDR_W, 10, memory word address width
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
SRC_BASE, 0, word address of source pixel (0,0)
DST_BASE, 256, word address of destination pixel (0,0)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  level from core control register; rising edge launches a run
mem_req  out  1  memory transaction request
mem_we  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  ADDR_W  word address; valid while mem_req
mem_ack  in  1  transaction complete; read data valid on this same cycle
win_load  out  1  strobe: capture read data into window slot win_idx
win_idx  out  4  window slot 0..8, row-major, 4=centre
calc_go  out  1  one-cycle pulse: datapath computes from window
calc_bypass  out  1  with calc_go: border pixel, result = centre unchanged
calc_done  in  1  datapath result ready; held until the next calc_go
busy  out  1  run in progress
done  out  1  one-cycle pulse on run completion

Behaviour:
- Reset: state=IDLE. mem_req, mem_we, win_load, calc_go, calc_bypass, busy and done all 0. mem_addr=0, win_idx=0, x=y=k=0. start_q=1, so a start held high through reset does not trigger. Reset mid-run abandons the run immediately, including any outstanding request; no done pulse is issued.
- Edge detect: start_q<=start every cycle. trig = start & ~start_q. trig is acted on only in IDLE; edges while busy are ignored and are not queued.
- IDLE: on trig, x=y=0, k=0, busy<=1, go to READ.
- border = (x==0)|(y==0)|(x==IMG_W-1)|(y==IMG_H-1).
- READ: interior pixels read k=0..8 at SRC_BASE+(y+dy)*IMG_W+(x+dx), with dy=k/3-1 and dx=k%3-1. Border pixels read only k=4 (centre).
  - mem_req=1, mem_we=0, address held stable until mem_ack is sampled high.
  - On the ack cycle: win_load=1 and win_idx=k (combinational with mem_ack).
  - mem_req=0 for exactly one cycle after each ack, then the next read issues.
  - After the last read, go to CALC.
- CALC: calc_go=1 for one cycle (calc_bypass=border), then wait in CALC_WAIT until calc_done=1. calc_done already high on the calc_go cycle is ignored; it is sampled from the following cycle.
- WRITE: mem_req=1, mem_we=1, mem_addr=DST_BASE+y*IMG_W+x, held until mem_ack, then go to NEXT.
- NEXT (1 cycle, mem_req=0):
  - x<IMG_W-1: x++.
  - else x=0; if y<IMG_H-1, y++; else go to DONE.
  - Otherwise k resets to 0 (border) or 0 for the first of 9 reads, and the block returns to READ.
- DONE: done=1 for one cycle, busy<=0, go to IDLE. A new trig is accepted from the cycle after DONE.
- Address arithmetic is computed at ADDR_W bits and wraps modulo 2^ADDR_W. No bounds checking.
- mem_ack while mem_req=0 is ignored. No timeout exists; a missing ack stalls the run indefinitely with busy=1.
- Latency per pixel with single-cycle-response memory (ack the cycle after req rises):
  - Interior: 9x(2+1) + 2 (calc, done next cycle) + 2 (write) + 1 (NEXT) = 32 cycles.
  - Border: 3+2+2+1 = 8 cycles.

Test Plan:
- IMG_W=IMG_H=4, ack 1 cycle after req, calc_done 1 cycle after calc_go; pulse start -> 48 reads, 16 writes at DST_BASE..DST_BASE+15 in raster order, 12 calc_bypass=1, single done pulse, busy high throughout.
- Interior pixel (1,1): read addresses in order SRC_BASE+0,1,2,4,5,6,8,9,10; win_idx 0..8 matches each ack; calc_go follows the 9th ack by 2 cycles.
- Hold start=1 across reset release -> no run; drop start and raise it again -> run starts, busy=1 two cycles later.
- Toggle start repeatedly mid-run -> no restart, write count remains 16, exactly one done pulse.
- Random 0-5 cycle ack delays and calc_done delays -> mem_addr/mem_we stable while mem_req is high, one gap cycle after every ack, output image matches the reference model.
- Assert reset during pixel (2,1) READ -> next cycle mem_req=busy=0; a new start edge restarts from pixel (0,0) at SRC_BASE.
